// File: rtl/floppy_pkg.sv
// Shared constants and state encoding for the floppy-drive stepper tone bank.
package floppy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOME = 2'd2
    } state_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 22;
    localparam int DEF_TRACKS      = 80;
    localparam int DEF_POS_W       = 7;
    localparam int DEF_HOME_PERIOD = 200000;

endpackage

// File: rtl/floppy_channel.sv
// One drive channel: plays a tone by toggling STEP, sweeps the head back and forth,
// and can drive the head to track 0 on request.
module floppy_channel
    import floppy_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TRACKS      = DEF_TRACKS,
    parameter int POS_W       = DEF_POS_W,
    parameter int HOME_PERIOD = DEF_HOME_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             home,
    input  logic [CNT_W-1:0] setpoint,
    output logic             step,
    output logic             dir,
    output logic             sel,
    output logic             homing,
    output logic             home_done
);

    localparam logic [CNT_W-1:0] HOME_SP  = CNT_W'(HOME_PERIOD);
    localparam logic [POS_W-1:0] TRACKS_P = POS_W'(TRACKS);
    localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

    state_e             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [POS_W-1:0]   pos_r, pos_s;
    logic               step_r, step_s;
    logic               dir_r, dir_s;
    logic               done_r, done_s;
    logic [CNT_W-1:0]   period_s;
    logic [CNT_W:0]     cnt_inc_s;
    logic               wrap_s;

    // Next-state, counter, position and pin logic for the channel FSM
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pos_s     = pos_r;
        step_s    = step_r;
        dir_s     = dir_r;
        done_s    = 1'b0;
        period_s  = (state_r == ST_HOME) ? HOME_SP : setpoint;
        // One bit wider so a counter at the top of its range cannot wrap past the setpoint
        cnt_inc_s = {1'b0, cnt_r} + CNT_ONE;
        wrap_s    = (cnt_inc_s >= {1'b0, period_s});

        case (state_r)
            ST_IDLE: begin
                cnt_s  = {CNT_W{1'b0}};
                step_s = 1'b1;
                if (home) begin
                    state_s = ST_HOME;
                    dir_s   = 1'b1;
                    pos_s   = {POS_W{1'b0}};
                end else if (enable && (setpoint != {CNT_W{1'b0}})) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (home) begin
                    state_s = ST_HOME;
                    dir_s   = 1'b1;
                    step_s  = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    pos_s   = {POS_W{1'b0}};
                end else if (!enable || (setpoint == {CNT_W{1'b0}})) begin
                    state_s = ST_IDLE;
                    step_s  = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (wrap_s) begin
                    cnt_s  = {CNT_W{1'b0}};
                    step_s = ~step_r;
                    // A 1->0 write is one head step; reverse at the end of the sweep
                    if (step_r) begin
                        if ((pos_r + POS_ONE) == TRACKS_P) begin
                            pos_s = {POS_W{1'b0}};
                            dir_s = ~dir_r;
                        end else begin
                            pos_s = pos_r + POS_ONE;
                        end
                    end else begin
                        pos_s = pos_r;
                    end
                end else begin
                    cnt_s = cnt_inc_s[CNT_W-1:0];
                end
            end
            ST_HOME: begin
                if (home) begin
                    dir_s  = 1'b1;
                    step_s = 1'b1;
                    cnt_s  = {CNT_W{1'b0}};
                    pos_s  = {POS_W{1'b0}};
                end else if (pos_r == TRACKS_P) begin
                    // All homing steps issued; release the drive on the following edge
                    state_s = ST_IDLE;
                    dir_s   = 1'b1;
                    pos_s   = {POS_W{1'b0}};
                    step_s  = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    done_s  = 1'b1;
                end else if (wrap_s) begin
                    cnt_s  = {CNT_W{1'b0}};
                    step_s = ~step_r;
                    if (step_r) begin
                        pos_s = pos_r + POS_ONE;
                    end else begin
                        pos_s = pos_r;
                    end
                end else begin
                    cnt_s = cnt_inc_s[CNT_W-1:0];
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                pos_s   = {POS_W{1'b0}};
                step_s  = 1'b1;
                dir_s   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            pos_r   <= {POS_W{1'b0}};
            step_r  <= 1'b1;
            dir_r   <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pos_r   <= pos_s;
            step_r  <= step_s;
            dir_r   <= dir_s;
            done_r  <= done_s;
        end
    end

    assign step      = step_r;
    assign dir       = dir_r;
    assign home_done = done_r;
    assign sel       = (state_r == ST_IDLE);
    assign homing    = (state_r == ST_HOME);

endmodule

// File: rtl/floppy_bank.sv
// Bank of independent floppy stepper tone channels; slices the packed setpoint bus
// and instantiates one channel per drive.
module floppy_bank
    import floppy_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TRACKS      = DEF_TRACKS,
    parameter int POS_W       = DEF_POS_W,
    parameter int HOME_PERIOD = DEF_HOME_PERIOD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*CNT_W-1:0] setpoint,
    input  logic [NUM_CH-1:0]       home,
    output logic [NUM_CH-1:0]       step,
    output logic [NUM_CH-1:0]       dir,
    output logic [NUM_CH-1:0]       sel,
    output logic [NUM_CH-1:0]       homing,
    output logic [NUM_CH-1:0]       home_done
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        floppy_channel #(
            .CNT_W       (CNT_W),
            .TRACKS      (TRACKS),
            .POS_W       (POS_W),
            .HOME_PERIOD (HOME_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable[i]),
            .home      (home[i]),
            .setpoint  (setpoint[i*CNT_W +: CNT_W]),
            .step      (step[i]),
            .dir       (dir[i]),
            .sel       (sel[i]),
            .homing    (homing[i]),
            .home_done (home_done[i])
        );
    end

endmodule

// File: tb/tb_floppy_bank.sv
// Randomised bench for floppy_bank with a behavioural per-channel model plus directed pins.
module tb_floppy_bank;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 22;
    localparam int TRACKS      = 4;
    localparam int POS_W       = 7;
    localparam int HOME_PERIOD = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*CNT_W-1:0] setpoint;
    logic [NUM_CH-1:0]       home;
    logic [NUM_CH-1:0]       step, dir, sel, homing, home_done;

    always #5 clk = ~clk;

    floppy_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TRACKS(TRACKS), .POS_W(POS_W), .HOME_PERIOD(HOME_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .setpoint(setpoint), .home(home),
        .step(step), .dir(dir), .sel(sel), .homing(homing), .home_done(home_done)
    );

    int passed = 0;
    int total  = 0;

    // Model: mode 0 = idle, 1 = playing, 2 = homing
    int m_mode[NUM_CH];
    int m_cnt[NUM_CH];
    int m_steps[NUM_CH];
    bit m_step[NUM_CH];
    bit m_dir[NUM_CH];
    bit m_done[NUM_CH];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int sp_of(int ch);
        return int'(setpoint[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic model_start_home(int ch);
        m_mode[ch] = 2; m_dir[ch] = 1'b1; m_step[ch] = 1'b1; m_cnt[ch] = 0; m_steps[ch] = 0;
    endtask

    // Advance one half-period tick; returns 1 when this edge writes STEP 1->0
    function automatic bit model_tick(int ch, int period);
        if (m_cnt[ch] + 1 >= period) begin
            m_cnt[ch]  = 0;
            m_step[ch] = !m_step[ch];
            return !m_step[ch];
        end
        m_cnt[ch]++;
        return 1'b0;
    endfunction

    task automatic model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            m_done[i] = 1'b0;
            if (rst) begin
                m_mode[i] = 0; m_cnt[i] = 0; m_steps[i] = 0; m_step[i] = 1'b1; m_dir[i] = 1'b1;
            end else if (home[i]) begin
                model_start_home(i);
            end else if (m_mode[i] == 0) begin
                if (enable[i] && sp_of(i) != 0) m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                if (!enable[i] || sp_of(i) == 0) begin
                    m_mode[i] = 0; m_step[i] = 1'b1; m_cnt[i] = 0;
                end else if (model_tick(i, sp_of(i))) begin
                    m_steps[i] = (m_steps[i] + 1) % TRACKS;
                    if (m_steps[i] == 0) m_dir[i] = !m_dir[i];
                end
            end else begin
                if (m_steps[i] == TRACKS) begin
                    m_mode[i] = 0; m_steps[i] = 0; m_step[i] = 1'b1; m_dir[i] = 1'b1;
                    m_cnt[i] = 0; m_done[i] = 1'b1;
                end else if (model_tick(i, HOME_PERIOD)) begin
                    m_steps[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] e_step, e_dir, e_sel, e_hom, e_done;
        for (int i = 0; i < NUM_CH; i++) begin
            e_step[i] = m_step[i];
            e_dir[i]  = m_dir[i];
            e_sel[i]  = (m_mode[i] == 0);
            e_hom[i]  = (m_mode[i] == 2);
            e_done[i] = m_done[i];
        end
        check("step", 64'(step), 64'(e_step));
        check("dir", 64'(dir), 64'(e_dir));
        check("sel", 64'(sel), 64'(e_sel));
        check("homing", 64'(homing), 64'(e_hom));
        check("home_done", 64'(home_done), 64'(e_done));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_sp(int ch, int val);
        setpoint[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = '0; home = '0; setpoint = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int falls, dones;
        bit prev;

        // 1: reset held three cycles
        rst = 1'b1; enable = '0; home = '0; setpoint = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_step", 64'(step), 64'hF);
        check("rst_dir", 64'(dir), 64'hF);
        check("rst_sel", 64'(sel), 64'hF);
        check("rst_homing", 64'(homing), 64'h0);

        // 2: setpoint 5, first toggle 5 edges after PLAY entry
        set_sp(0, 5); enable[0] = 1'b1;
        tick();
        check("play_sel0", 64'(sel[0]), 64'h0);
        repeat (4) tick();
        check("pre_toggle", 64'(step[0]), 64'h1);
        tick();
        check("first_toggle", 64'(step[0]), 64'h0);
        repeat (5) tick();
        check("second_toggle", 64'(step[0]), 64'h1);

        // 3: direction reverses every TRACKS falling edges
        do_reset();
        set_sp(0, 2); enable[0] = 1'b1;
        falls = 0;
        for (int n = 0; n < 60 && falls < 8; n++) begin
            prev = step[0];
            tick();
            if (prev && !step[0]) begin
                falls++;
                if (falls == 3) check("dir_fall3", 64'(dir[0]), 64'h1);
                if (falls == 4) check("dir_fall4", 64'(dir[0]), 64'h0);
                if (falls == 8) check("dir_fall8", 64'(dir[0]), 64'h1);
            end
        end
        check("dir_falls_seen", 64'(falls), 64'd8);

        // 4: lowering the setpoint below the running count
        do_reset();
        set_sp(0, 100); enable[0] = 1'b1;
        tick();
        repeat (50) tick();
        check("long_half", 64'(step[0]), 64'h1);
        set_sp(0, 3);
        tick();
        check("lowered_toggle", 64'(step[0]), 64'h0);
        repeat (2) tick();
        check("lowered_hold", 64'(step[0]), 64'h0);
        tick();
        check("lowered_period", 64'(step[0]), 64'h1);
        set_sp(0, 0);
        tick();
        check("silent_sel", 64'(sel[0]), 64'h1);
        check("silent_step", 64'(step[0]), 64'h1);

        // 5: home pulse while playing
        do_reset();
        set_sp(1, 3); enable[1] = 1'b1;
        repeat (10) tick();
        home[1] = 1'b1;
        tick();
        home[1] = 1'b0;
        check("home_homing", 64'(homing[1]), 64'h1);
        check("home_dir", 64'(dir[1]), 64'h1);
        check("home_step", 64'(step[1]), 64'h1);
        falls = 0; dones = 0;
        for (int n = 0; n < 60; n++) begin
            prev = step[1];
            tick();
            if (prev && !step[1]) falls++;
            if (home_done[1]) dones++;
            if (sel[1]) break;
        end
        check("home_sel", 64'(sel[1]), 64'h1);
        enable[1] = 1'b0;
        repeat (4) begin
            tick();
            if (home_done[1]) dones++;
        end
        check("home_falls", 64'(falls), 64'd4);
        check("home_done_once", 64'(dones), 64'd1);

        // 6: reset during homing and playing
        do_reset();
        set_sp(3, 2); enable[3] = 1'b1; home[2] = 1'b1;
        tick();
        home[2] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midrst_step", 64'(step), 64'hF);
        check("midrst_dir", 64'(dir), 64'hF);
        check("midrst_sel", 64'(sel), 64'hF);
        check("midrst_homing", 64'(homing), 64'h0);
        rst = 1'b0; enable = '0;
        dones = 0;
        repeat (20) begin
            tick();
            if (home_done != '0) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 19) == 0) enable[c] = !enable[c];
                home[c] = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 29) == 0)
                    set_sp(c, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6));
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
